// File: rtl/regs_wb_pkg.sv
// Shared writeback constants: register bus widths, the x0 index and the
// producer source encodings used by the round-robin arbiter.
package regs_wb_pkg;

    localparam int REG_BUS      = 64;
    localparam int REG_ADDR_BUS = 5;
    localparam logic [REG_ADDR_BUS-1:0] REG_ZERO = '0;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    function automatic wb_src_e other_src(input wb_src_e src);
        return (src == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/regs_wb_fifo.sv
// Small per-producer writeback queue (wb_fifo); every slot and its valid bit
// are visible so the scoreboard can search pending writes.
module wb_fifo #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 5,
    parameter int DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [IDX_W-1:0]               push_idx,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [IDX_W-1:0]               head_idx,
    output logic [DATA_W-1:0]              head_data,
    output logic [DEPTH-1:0][IDX_W-1:0]    entry_idx,
    output logic [DEPTH-1:0][DATA_W-1:0]   entry_data,
    output logic [DEPTH-1:0]               entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]                rd_ptr;
    logic [PTR_W-1:0]                wr_ptr;
    logic [CNT_W-1:0]                count;
    logic [DEPTH-1:0][IDX_W-1:0]     idx_mem;
    logic [DEPTH-1:0][DATA_W-1:0]    data_mem;
    logic                            do_push;
    logic                            do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            idx_mem[wr_ptr]  <= push_idx;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_idx   = idx_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign entry_idx  = idx_mem;
    assign entry_data = data_mem;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off         = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(off) < count);
        end
    end

endmodule

// File: rtl/regs_wb.sv
// Writeback collector: two producer queues, round-robin retire into the
// register-file write port, pending-write scoreboard; REGS_WB_FWD_EN adds forwarding.
module regs_wb
    import regs_wb_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int IDX_W  = REG_ADDR_BUS,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [IDX_W-1:0]  alu_idx_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [IDX_W-1:0]  lsu_idx_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic [IDX_W-1:0]  widx_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    input  logic [IDX_W-1:0]  ridx1_i,
    input  logic [IDX_W-1:0]  ridx2_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic [DATA_W-1:0] fwd1_data_o,
    output logic [DATA_W-1:0] fwd2_data_o
);

    logic                          alu_full, alu_empty, lsu_full, lsu_empty;
    logic [IDX_W-1:0]              alu_head_idx, lsu_head_idx, sel_idx;
    logic [DATA_W-1:0]             alu_head_data, lsu_head_data, sel_data;
    logic [DEPTH-1:0][IDX_W-1:0]   alu_eidx, lsu_eidx;
    logic [DEPTH-1:0][DATA_W-1:0]  alu_edata, lsu_edata;
    logic [DEPTH-1:0]              alu_evalid, lsu_evalid;
    logic                          grant_alu, grant_lsu;
    wb_src_e                       rr;
    logic [1:0][IDX_W-1:0]         ridx;
    logic [1:0]                    busy;

    assign alu_ready_o = !alu_full && !rst;
    assign lsu_ready_o = !lsu_full && !rst;

    wb_fifo #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst),
        .push(alu_valid_i && alu_ready_o), .push_idx(alu_idx_i), .push_data(alu_data_i),
        .pop(grant_alu), .full(alu_full), .empty(alu_empty),
        .head_idx(alu_head_idx), .head_data(alu_head_data),
        .entry_idx(alu_eidx), .entry_data(alu_edata), .entry_valid(alu_evalid)
    );

    wb_fifo #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) u_lsu_fifo (
        .clk(clk), .rst(rst),
        .push(lsu_valid_i && lsu_ready_o), .push_idx(lsu_idx_i), .push_data(lsu_data_i),
        .pop(grant_lsu), .full(lsu_full), .empty(lsu_empty),
        .head_idx(lsu_head_idx), .head_data(lsu_head_data),
        .entry_idx(lsu_eidx), .entry_data(lsu_edata), .entry_valid(lsu_evalid)
    );

    // rr only matters when both heads compete; a lone head is granted directly.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!alu_empty && !lsu_empty) begin
            grant_alu = (rr == WB_SRC_ALU);
            grant_lsu = (rr == WB_SRC_LSU);
        end else begin
            grant_alu = !alu_empty;
            grant_lsu = !lsu_empty;
        end
    end

    assign sel_idx  = grant_alu ? alu_head_idx  : lsu_head_idx;
    assign sel_data = grant_alu ? alu_head_data : lsu_head_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr      <= WB_SRC_LSU;
            we_o    <= 1'b0;
            widx_o  <= '0;
            wdata_o <= '0;
        end else begin
            if (!alu_empty && !lsu_empty) rr <= other_src(rr);
            if (grant_alu || grant_lsu) begin
                widx_o  <= sel_idx;
                wdata_o <= sel_data;
                we_o    <= (sel_idx != IDX_W'(REG_ZERO));
            end else begin
                we_o    <= 1'b0;
            end
        end
    end

    assign ridx    = {ridx2_i, ridx1_i};
    assign busy1_o = busy[0];
    assign busy2_o = busy[1];

`ifdef REGS_WB_FWD_EN
    logic [1:0][DATA_W-1:0] fwd;

    // Queue hits are OR-merged: at most one pending entry can match an index.
    always_comb begin
        logic              q_hit;
        logic [DATA_W-1:0] q_data;
        q_hit  = 1'b0;
        q_data = '0;
        busy   = '0;
        fwd    = '0;
        for (int p = 0; p < 2; p++) begin
            q_hit  = 1'b0;
            q_data = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_evalid[i] && alu_eidx[i] == ridx[p]) begin
                    q_hit  = 1'b1;
                    q_data = q_data | alu_edata[i];
                end
                if (lsu_evalid[i] && lsu_eidx[i] == ridx[p]) begin
                    q_hit  = 1'b1;
                    q_data = q_data | lsu_edata[i];
                end
            end
            busy[p] = (ridx[p] != IDX_W'(REG_ZERO)) &&
                      (q_hit || (we_o && widx_o == ridx[p]));
            if (busy[p]) fwd[p] = q_hit ? q_data : wdata_o;
        end
    end

    assign fwd1_data_o = fwd[0];
    assign fwd2_data_o = fwd[1];
`else
    logic unused_entry_data;

    always_comb begin
        logic q_hit;
        q_hit = 1'b0;
        busy  = '0;
        for (int p = 0; p < 2; p++) begin
            q_hit = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if ((alu_evalid[i] && alu_eidx[i] == ridx[p]) ||
                    (lsu_evalid[i] && lsu_eidx[i] == ridx[p]))
                    q_hit = 1'b1;
            end
            busy[p] = (ridx[p] != IDX_W'(REG_ZERO)) &&
                      (q_hit || (we_o && widx_o == ridx[p]));
        end
    end

    assign unused_entry_data = ^{alu_edata, lsu_edata};
    assign fwd1_data_o       = '0;
    assign fwd2_data_o       = '0;
`endif

endmodule
